// File: rtl/muldiv_ctrl_if.sv
// EX-stage request/response bundle for the HI/LO multiply/divide sequencer.
// The master modport is the issuing pipeline stage; the slave modport is muldiv_ctrl.
interface muldiv_ctrl_if;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output op_valid, op, a, b, cancel, input busy, done, hi, lo);
    modport slave  (input op_valid, op, a, b, cancel, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_ctrl.sv
// HI/LO owner: latency-timed multiply, radix-2 restoring divide, single-cycle MTHI/MTLO.
// Define DIV_ZERO_FAST_EN to finish divide-by-zero in one busy cycle instead of 33.
module muldiv_ctrl #(
    parameter int MUL_CYCLES = 2
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [5:0] MUL_LAST = 6'(MUL_CYCLES - 1);
    localparam logic [5:0] DIV_LAST = 6'd31;

    state_t      state, state_nxt;
    logic [5:0]  cnt;
    logic [32:0] mul_a, mul_b;
    logic [31:0] rem, quo, dvs;
    logic        qneg, rneg;
    logic [31:0] hi_q, lo_q;
    logic        done_q;

    logic        accept, is_signed, div_zero_fast, mul_fin, fix_fin;
    logic [31:0] abs_a, abs_b;
    logic [63:0] prod;
    logic [32:0] rem_shift, rem_trial;

    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        is_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
        abs_a     = (is_signed && bus.a[31]) ? -bus.a : bus.a;
        abs_b     = (is_signed && bus.b[31]) ? -bus.b : bus.b;
`ifdef DIV_ZERO_FAST_EN
        div_zero_fast = (bus.b == 32'd0);
`else
        div_zero_fast = 1'b0;
`endif
        // Operands are already 33-bit extended; the low 64 bits of the wrapped product are exact.
        prod      = {{31{mul_a[32]}}, mul_a} * {{31{mul_b[32]}}, mul_b};
        rem_shift = {rem, quo[31]};
        rem_trial = rem_shift - {1'b0, dvs};

        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.op_valid && !bus.cancel) begin
                    accept = 1'b1;
                    if (bus.op == OP_MULT || bus.op == OP_MULTU) begin
                        state_nxt = MUL;
                    end else if (bus.op == OP_DIV || bus.op == OP_DIVU) begin
                        state_nxt = div_zero_fast ? FIX : DIV;
                    end
                end
            end
            MUL:     if (bus.cancel || cnt == MUL_LAST) state_nxt = IDLE;
            DIV:     if (bus.cancel) state_nxt = IDLE;
                     else if (cnt == DIV_LAST) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        mul_fin = (state == MUL) && !bus.cancel && (cnt == MUL_LAST);
        fix_fin = (state == FIX) && !bus.cancel;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            mul_a  <= '0;
            mul_b  <= '0;
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
            qneg   <= 1'b0;
            rneg   <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= mul_fin || fix_fin;
            cnt    <= (state == MUL || state == DIV) ? cnt + 6'd1 : 6'd0;

            if (accept) begin
                case (bus.op)
                    OP_MTHI: hi_q <= bus.a;
                    OP_MTLO: lo_q <= bus.a;
                    OP_MULT, OP_MULTU: begin
                        mul_a <= {is_signed & bus.a[31], bus.a};
                        mul_b <= {is_signed & bus.b[31], bus.b};
                    end
                    OP_DIV, OP_DIVU: begin
                        if (div_zero_fast) begin
                            // Raw a and all-ones quotient bypass the sign fix-up.
                            rem  <= bus.a;
                            quo  <= '1;
                            qneg <= 1'b0;
                            rneg <= 1'b0;
                        end else begin
                            rem  <= '0;
                            quo  <= abs_a;
                            dvs  <= abs_b;
                            qneg <= is_signed & (bus.a[31] ^ bus.b[31]);
                            rneg <= is_signed & bus.a[31];
                        end
                    end
                    default: ;
                endcase
            end

            if (state == DIV) begin
                if (!rem_trial[32]) begin
                    rem <= rem_trial[31:0];
                    quo <= {quo[30:0], 1'b1};
                end else begin
                    rem <= rem_shift[31:0];
                    quo <= {quo[30:0], 1'b0};
                end
            end

            if (mul_fin) {hi_q, lo_q} <= prod;
            if (fix_fin) begin
                hi_q <= rneg ? -rem : rem;
                lo_q <= qneg ? -quo : quo;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: transaction-level HI/LO model compared every cycle,
// directed literal cases, then randomized ops with cancel and reset.
module tb_muldiv_ctrl;
    localparam int MUL_CYCLES = 2;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

`ifdef DIV_ZERO_FAST_EN
    localparam int DIV0_BUSY = 1;
`else
    localparam int DIV0_BUSY = 33;
`endif

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    bit   chk_en   = 1'b0;

    muldiv_ctrl_if bus ();

    muldiv_ctrl #(.MUL_CYCLES(MUL_CYCLES)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the architectural definitions.
    function automatic logic [63:0] multiply(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy;
        if (o == OP_MULT) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
        end else begin
            sx = longint'({32'd0, x});
            sy = longint'({32'd0, y});
        end
        return 64'(sx * sy);
    endfunction

    function automatic void divide(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] q, output logic [31:0] r);
        bit          sgn;
        logic [31:0] ua, ub;
        sgn = (o == OP_DIV);
        ua  = (sgn && x[31]) ? -x : x;
        ub  = (sgn && y[31]) ? -y : y;
        if (ub == 32'd0) begin
            q = '1;
            r = ua;
        end else begin
            q = ua / ub;
            r = ua % ub;
        end
        if (sgn && (x[31] ^ y[31])) q = -q;
        if (sgn && x[31])           r = -r;
`ifdef DIV_ZERO_FAST_EN
        if (y == 32'd0) begin
            q = '1;
            r = x;
        end
`endif
    endfunction

    // Model: remaining busy cycles and the pending result that lands when they run out.
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    int          m_left;
    logic        m_done;

    always @(posedge clk) begin : model
        int          left;
        logic [31:0] nh, nl, ph, pl, q, r;
        logic        d;
        left = m_left; nh = m_hi; nl = m_lo; ph = p_hi; pl = p_lo; d = 1'b0;
        if (reset) begin
            left = 0; nh = '0; nl = '0;
        end else if (left > 0) begin
            if (bus.cancel) begin
                left = 0;
            end else begin
                left--;
                if (left == 0) begin
                    nh = ph; nl = pl; d = 1'b1;
                end
            end
        end else if (bus.op_valid && !bus.cancel) begin
            case (bus.op)
                OP_MULT, OP_MULTU: begin
                    {ph, pl} = multiply(bus.op, bus.a, bus.b);
                    left = MUL_CYCLES;
                end
                OP_DIV, OP_DIVU: begin
                    divide(bus.op, bus.a, bus.b, q, r);
                    pl = q; ph = r;
                    left = (bus.b == 32'd0) ? DIV0_BUSY : 33;
                end
                OP_MTHI: nh = bus.a;
                OP_MTLO: nl = bus.a;
                default: ;
            endcase
        end
        m_left <= left; m_hi <= nh; m_lo <= nl; p_hi <= ph; p_lo <= pl; m_done <= d;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_busy", bus.busy, m_left > 0);
            check("cyc_done", bus.done, m_done);
            check("cyc_hi",   bus.hi,   m_hi);
            check("cyc_lo",   bus.lo,   m_lo);
        end
    end

    // Called at a negedge with the DUT idle; returns at the first negedge with busy low.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, output int nbusy);
        bus.op_valid = 1'b1; bus.op = o; bus.a = x; bus.b = y;
        @(negedge clk);
        bus.op_valid = 1'b0;
        nbusy = 0;
        while (bus.busy && nbusy < 200) begin
            nbusy++;
            @(negedge clk);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int nb;
        reset = 1'b1;
        bus.op_valid = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.cancel = 1'b0;
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        chk_en = 1'b1;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_hi",   bus.hi,   0);
        check("rst_lo",   bus.lo,   0);

        run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, nb);
        check("mult_cycles", nb, MUL_CYCLES);
        check("mult_done",   bus.done, 1);
        check("mult_hi",     bus.hi, 32'hFFFF_FFFF);
        check("mult_lo",     bus.lo, 32'hFFFF_FFFA);

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, nb);
        check("multu_cycles", nb, MUL_CYCLES);
        check("multu_hi",     bus.hi, 32'hFFFF_FFFE);
        check("multu_lo",     bus.lo, 32'h0000_0001);

        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, nb);
        check("div_cycles", nb, 33);
        check("div_done",   bus.done, 1);
        check("div_lo",     bus.lo, 32'hFFFF_FFFD);
        check("div_hi",     bus.hi, 32'hFFFF_FFFF);

        run_op(OP_DIVU, 32'd100, 32'd7, nb);
        check("divu_lo", bus.lo, 14);
        check("divu_hi", bus.hi, 2);

        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, nb);
        check("divmin_lo", bus.lo, 32'h8000_0000);
        check("divmin_hi", bus.hi, 0);

        run_op(OP_MTHI, 32'h1234_5678, 32'd0, nb);
        check("mthi_hi",   bus.hi, 32'h1234_5678);
        check("mthi_busy", nb, 0);
        check("mthi_done", bus.done, 0);
        run_op(OP_MTLO, 32'h9ABC_DEF0, 32'd0, nb);
        check("mtlo_lo",   bus.lo, 32'h9ABC_DEF0);
        check("mtlo_hi",   bus.hi, 32'h1234_5678);
        check("mtlo_done", bus.done, 0);

        // Cancel mid-divide leaves HI/LO alone; op_valid with cancel is dropped.
        run_op(OP_MTHI, 32'h11, 32'd0, nb);
        run_op(OP_MTLO, 32'h22, 32'd0, nb);
        bus.op_valid = 1'b1; bus.op = OP_DIVU; bus.a = 32'd1000; bus.b = 32'd3;
        @(negedge clk);
        bus.op_valid = 1'b0;
        repeat (10) @(negedge clk);
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        check("cancel_busy", bus.busy, 0);
        check("cancel_hi",   bus.hi, 32'h11);
        check("cancel_lo",   bus.lo, 32'h22);
        bus.op_valid = 1'b1; bus.op = OP_MTHI; bus.a = 32'hDEAD; bus.cancel = 1'b1;
        @(negedge clk);
        bus.op_valid = 1'b0; bus.cancel = 1'b0;
        check("cancel_done",   bus.done, 0);
        check("dropped_op_hi", bus.hi, 32'h11);

        run_op(OP_DIVU, 32'd5, 32'd0, nb);
        check("div0u_cycles", nb, DIV0_BUSY);
        check("div0u_lo",     bus.lo, 32'hFFFF_FFFF);
        check("div0u_hi",     bus.hi, 5);
        run_op(OP_DIV, 32'hFFFF_FFFB, 32'd0, nb);
`ifdef DIV_ZERO_FAST_EN
        check("div0s_lo", bus.lo, 32'hFFFF_FFFF);
`else
        check("div0s_lo", bus.lo, 32'h0000_0001);
`endif
        check("div0s_hi", bus.hi, 32'hFFFF_FFFB);

        // Reset in the middle of a divide.
        bus.op_valid = 1'b1; bus.op = OP_DIV; bus.a = 32'd12345; bus.b = 32'd7;
        @(negedge clk);
        bus.op_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy", bus.busy, 0);
        check("midrst_hi",   bus.hi, 0);
        check("midrst_lo",   bus.lo, 0);

        for (int i = 0; i < 4000; i++) begin
            bus.op_valid = ($urandom_range(0, 1) == 1);
            bus.op       = 3'($urandom_range(0, 7));
            bus.a        = pick();
            bus.b        = pick();
            bus.cancel   = ($urandom_range(0, 99) < 2);
            reset        = ($urandom_range(0, 999) == 0);
            @(negedge clk);
        end
        bus.op_valid = 1'b0; bus.cancel = 1'b0; reset = 1'b0;
        repeat (40) @(negedge clk);
        check("final_idle", bus.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
